sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that multiplexes NUM_PORTS requesters onto one SDRAM controller port.
// Only one transaction is outstanding; completion, controller error or timeout releases the grant.
module sdram_arbiter #(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                p_rd,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] p_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     p_wdata,
  output logic [NUM_PORTS-1:0]                p_ack,
  output logic [NUM_PORTS-1:0]                p_rvalid,
  output logic [NUM_PORTS-1:0]                p_wvalid,
  output logic [NUM_PORTS-1:0]                p_err,
  output logic [DATA_WIDTH-1:0]               p_rdata,
  output logic                                c_rd,
  output logic [DATA_WIDTH/8-1:0]             c_wr,
  output logic [ADDR_WIDTH-1:0]               c_addr,
  output logic [DATA_WIDTH-1:0]               c_wdata,
  input  logic                                c_rdy,
  input  logic                                c_rvalid,
  input  logic                                c_wvalid,
  input  logic                                c_err,
  input  logic [DATA_WIDTH-1:0]               c_rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_g;
  logic [CW-1:0]        r_cnt;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_any;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_ptr_next;
  logic                 w_g_rd;
  logic [BYTES-1:0]     w_g_wr;
  logic                 w_issue;
  logic                 w_wait;
  logic                 w_cmpl;
  logic                 w_timeout;
  logic [NUM_PORTS-1:0] w_g_onehot;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req[i] = p_rd[i] | (|p_wr[i*BYTES +: BYTES]);
    end
  end

  // First requester at or after r_ptr, wrapping at NUM_PORTS.
  always_comb begin
    int unsigned   idx;
    logic [PW-1:0] cand;
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PW'(idx);
      if (!w_any && w_req[cand]) begin
        w_any = 1'b1;
        w_win = cand;
      end
    end
  end

  assign w_ptr_next = (r_g == PW'(NUM_PORTS - 1)) ? '0 : r_g + PW'(1);

  assign w_g_rd     = p_rd[r_g];
  assign w_g_wr     = p_wr[r_g*BYTES +: BYTES];
  assign w_g_onehot = NUM_PORTS'(1) << r_g;

  // Outputs are gated by rst so nothing leaks while reset is held.
  assign w_issue   = !rst && (r_state == S_ISSUE);
  assign w_wait    = !rst && (r_state == S_WAIT);
  assign w_cmpl    = c_rvalid | c_wvalid | c_err;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC));

  assign c_rd    = w_issue & w_g_rd;
  assign c_wr    = (w_issue && !w_g_rd) ? w_g_wr : '0;
  assign c_addr  = p_addr[r_g*ADDR_WIDTH +: ADDR_WIDTH];
  assign c_wdata = p_wdata[r_g*DATA_WIDTH +: DATA_WIDTH];

  assign p_ack    = (w_issue && c_rdy)    ? w_g_onehot : '0;
  assign p_rvalid = (w_wait && c_rvalid)  ? w_g_onehot : '0;
  assign p_wvalid = (w_wait && c_wvalid)  ? w_g_onehot : '0;
  assign p_rdata  = (w_wait && c_rvalid)  ? c_rdata    : '0;
  // A real completion on the timeout cycle suppresses the timeout error.
  assign p_err    = (w_wait && (c_err || (w_timeout && !c_rvalid && !c_wvalid))) ?
                    w_g_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g     <= w_win;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (c_rdy) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_cmpl || w_timeout) begin
            r_ptr   <= w_ptr_next;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 24;
  localparam int BY = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  p_rd;
  logic [N*BY-1:0] p_wr;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wdata;
  logic [N-1:0]  p_ack, p_rvalid, p_wvalid, p_err;
  logic [DW-1:0] p_rdata;
  logic          c_rd;
  logic [BY-1:0] c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_rdy, c_rvalid, c_wvalid, c_err;
  logic [DW-1:0] c_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NUM_PORTS  (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p_rd    (p_rd),
    .p_wr    (p_wr),
    .p_addr  (p_addr),
    .p_wdata (p_wdata),
    .p_ack   (p_ack),
    .p_rvalid(p_rvalid),
    .p_wvalid(p_wvalid),
    .p_err   (p_err),
    .p_rdata (p_rdata),
    .c_rd    (c_rd),
    .c_wr    (c_wr),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_rdy   (c_rdy),
    .c_rvalid(c_rvalid),
    .c_wvalid(c_wvalid),
    .c_err   (c_err),
    .c_rdata (c_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_rd = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
    c_rdy = 1'b0; c_rvalid = 1'b0; c_wvalid = 1'b0; c_err = 1'b0; c_rdata = '0;
  endtask

  // Leaves the bench in the first cycle after reset with rst low.
  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_port(input int i, input logic rd, input logic [BY-1:0] wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_rd[i] = rd;
    p_wr[i*BY +: BY] = wr;
    p_addr[i*AW +: AW] = a;
    p_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    p_rd = '1; p_wr = '1; c_rdy = 1'b1; c_rvalid = 1'b1; c_wvalid = 1'b1; c_err = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({p_ack, p_rvalid, p_wvalid, p_err} !== '0) begin
        bad++; $display("FAIL rst_pulses got=%h want=0", {p_ack, p_rvalid, p_wvalid, p_err});
      end
      total++;
      if ({c_rd, c_wr} !== '0) begin
        bad++; $display("FAIL rst_ctrl got=%h want=0", {c_rd, c_wr});
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if ({p_ack, p_rvalid, p_wvalid, p_err, c_rd, c_wr} !== '0) begin
      bad++; $display("FAIL rst_after got=%h want=0",
                      {p_ack, p_rvalid, p_wvalid, p_err, c_rd, c_wr});
    end
    tick();
    total++;
    if ({c_rd, c_wr, p_ack} !== {1'b1, 4'h0, 3'b001}) begin
      bad++; $display("FAIL rst_first_grant got=%h want=%h", {c_rd, c_wr, p_ack},
                      {1'b1, 4'h0, 3'b001});
    end
  endtask

  task automatic test_single_read();
    reset_dut();
    set_port(1, 1'b1, 4'h0, 24'h000100, 32'h0);
    c_rdy = 1'b1;
    #1;
    total++;
    if (c_rd !== 1'b0) begin bad++; $display("FAIL sr_idle_crd got=%b want=0", c_rd); end
    tick();
    #1;
    total++;
    if ({c_rd, c_addr, p_ack} !== {1'b1, 24'h000100, 3'b010}) begin
      bad++; $display("FAIL sr_issue got=%h want=%h", {c_rd, c_addr, p_ack},
                      {1'b1, 24'h000100, 3'b010});
    end
    tick();
    set_port(1, 1'b0, 4'h0, 24'h0, 32'h0);
    c_rvalid = 1'b1; c_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if (p_rvalid !== 3'b010) begin bad++; $display("FAIL sr_rvalid got=%b want=010", p_rvalid); end
    total++;
    if (p_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sr_rdata got=%h want=deadbeef", p_rdata);
    end
    total++;
    if ({p_ack, p_wvalid, p_err, c_rd} !== '0) begin
      bad++; $display("FAIL sr_silent got=%h want=0", {p_ack, p_wvalid, p_err, c_rd});
    end
    tick();
    c_rvalid = 1'b0;
    #1;
    total++;
    if ({p_rvalid, p_rdata} !== '0) begin
      bad++; $display("FAIL sr_after got=%h want=0", {p_rvalid, p_rdata});
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_ptr;
    logic cmpl;
    reset_dut();
    for (int i = 0; i < N; i++) set_port(i, 1'b1, 4'h0, AW'(24'h1000 * (i + 1)), 32'h0);
    c_rdy = 1'b1;
    cmpl = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      c_rvalid = cmpl;
      #1;
      cmpl = 1'b0;
      for (int i = 0; i < N; i++) if (p_ack[i]) got.push_back(i);
      if (p_ack != '0) cmpl = 1'b1;
      tick();
    end
    c_rvalid = 1'b0;
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL rr_count got=%0d want=4", got.size());
    end else begin
      exp_ptr = 0;
      for (int j = 0; j < 4; j++) begin
        // every port requests, so the winner is the pointer itself
        total++;
        if (got[j] != exp_ptr) begin
          bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", j, got[j], exp_ptr);
        end
        exp_ptr = (exp_ptr + 1) % N;
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    set_port(2, 1'b0, 4'hF, 24'h0ABCDE, 32'h12345678);
    c_rdy = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({c_wr, c_addr, c_wdata, p_ack} !== {4'hF, 24'h0ABCDE, 32'h12345678, 3'b000}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", c,
                        {c_wr, c_addr, c_wdata, p_ack},
                        {4'hF, 24'h0ABCDE, 32'h12345678, 3'b000});
      end
      tick();
    end
    c_rdy = 1'b1;
    #1;
    total++;
    if (p_ack !== 3'b100) begin bad++; $display("FAIL bp_ack got=%b want=100", p_ack); end
    tick();
    set_port(2, 1'b0, 4'h0, 24'h0, 32'h0);
    #1;
    total++;
    if ({p_ack, c_wr} !== '0) begin
      bad++; $display("FAIL bp_once got=%h want=0", {p_ack, c_wr});
    end
    c_wvalid = 1'b1;
    #1;
    total++;
    if (p_wvalid !== 3'b100) begin bad++; $display("FAIL bp_wvalid got=%b want=100", p_wvalid); end
    tick();
    c_wvalid = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    logic found;
    reset_dut();
    set_port(0, 1'b1, 4'h0, 24'h000A00, 32'h0);
    c_rdy = 1'b1;
    tick();
    #1;
    total++;
    if (p_ack !== 3'b001) begin bad++; $display("FAIL to_ack got=%b want=001", p_ack); end
    tick();
    // port 0 re-requests so a stuck pointer would grant it again
    set_port(0, 1'b1, 4'h0, 24'h000A00, 32'h0);
    set_port(1, 1'b1, 4'h0, 24'h000B00, 32'h0);
    n = 0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (p_err != '0) begin found = 1'b1; break; end
      n++;
      tick();
    end
    total++;
    if (!found || n != TO || p_err !== 3'b001) begin
      bad++; $display("FAIL to_err found=%b cycles=%0d err=%b want cycles=%0d err=001",
                      found, n, p_err, TO);
    end
    tick();
    tick();
    #1;
    total++;
    if ({c_rd, c_addr, p_ack} !== {1'b1, 24'h000B00, 3'b010}) begin
      bad++; $display("FAIL to_next got=%h want=%h", {c_rd, c_addr, p_ack},
                      {1'b1, 24'h000B00, 3'b010});
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    set_port(2, 1'b0, 4'hF, 24'h000C00, 32'hCAFE0001);
    c_rdy = 1'b1;
    tick();
    tick();
    set_port(2, 1'b0, 4'h0, 24'h0, 32'h0);
    repeat (TO) tick();
    c_wvalid = 1'b1;
    #1;
    total++;
    if (p_wvalid !== 3'b100) begin bad++; $display("FAIL sim_wvalid got=%b want=100", p_wvalid); end
    total++;
    if (p_err !== 3'b000) begin bad++; $display("FAIL sim_noerr got=%b want=000", p_err); end
    tick();
    #1;
    total++;
    if ({p_ack, p_rvalid, p_wvalid, p_err} !== '0) begin
      bad++; $display("FAIL sim_stray got=%h want=0", {p_ack, p_rvalid, p_wvalid, p_err});
    end
    c_wvalid = 1'b0;
    reset_dut();
    set_port(0, 1'b1, 4'hF, 24'h000D00, 32'h0);
    tick();
    #1;
    total++;
    if ({c_rd, c_wr} !== {1'b1, 4'h0}) begin
      bad++; $display("FAIL sim_rdwins got=%h want=%h", {c_rd, c_wr}, {1'b1, 4'h0});
    end
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    set_port(1, 1'b1, 4'h0, 24'h000E00, 32'h0);
    c_rdy = 1'b1;
    tick();
    tick();
    set_port(1, 1'b0, 4'h0, 24'h0, 32'h0);
    rst = 1'b1;
    c_rvalid = 1'b1; c_rdata = 32'h0BADF00D;
    #1;
    total++;
    if ({p_ack, p_rvalid, p_wvalid, p_err, p_rdata} !== '0) begin
      bad++; $display("FAIL rmw_during got=%h want=0", {p_ack, p_rvalid, p_wvalid, p_err, p_rdata});
    end
    tick();
    rst = 1'b0;
    set_port(0, 1'b1, 4'h0, 24'h000F00, 32'h0);
    set_port(2, 1'b1, 4'h0, 24'h000F20, 32'h0);
    #1;
    total++;
    if ({p_ack, p_rvalid, p_wvalid, p_err, p_rdata, c_rd} !== '0) begin
      bad++; $display("FAIL rmw_after got=%h want=0",
                      {p_ack, p_rvalid, p_wvalid, p_err, p_rdata, c_rd});
    end
    c_rvalid = 1'b0;
    tick();
    #1;
    total++;
    if ({c_rd, c_addr, p_ack} !== {1'b1, 24'h000F00, 3'b001}) begin
      bad++; $display("FAIL rmw_ptr0 got=%h want=%h", {c_rd, c_addr, p_ack},
                      {1'b1, 24'h000F00, 3'b001});
    end
  endtask

  typedef enum int {MFree, MIssue, MWait} mph_t;

  task automatic test_random();
    bit            pend[N];
    bit            pend_rd[N];
    logic [BY-1:0] pend_wr[N];
    logic [AW-1:0] pend_addr[N];
    logic [DW-1:0] pend_data[N];
    mph_t          m_ph;
    int            m_ptr, m_g, m_cnt, lat, n_done, kind, w;
    bit            op_rd, any;
    logic [N-1:0]  oh, e_ack, e_rv, e_wv, e_er;
    logic [BY-1:0] e_wr;
    logic          e_rd;
    reset_dut();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    m_ph = MFree; m_ptr = 0; m_g = 0; m_cnt = 0; lat = 0; n_done = 0; op_rd = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          kind = int'($urandom_range(0, 3));
          pend[i] = 1'b1;
          pend_rd[i] = (kind == 0 || kind == 3);
          pend_wr[i] = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          pend_addr[i] = 24'($urandom);
          pend_data[i] = $urandom;
        end
        if (pend[i]) set_port(i, pend_rd[i], pend_wr[i], pend_addr[i], pend_data[i]);
        else set_port(i, 1'b0, 4'h0, 24'h0, 32'h0);
      end
      c_rdy = ($urandom_range(0, 2) != 0);
      c_rvalid = 1'b0; c_wvalid = 1'b0; c_err = 1'b0; c_rdata = $urandom;
      if (m_ph == MWait && m_cnt == lat) begin
        if ($urandom_range(0, 7) == 0) c_err = 1'b1;
        else if (op_rd) c_rvalid = 1'b1;
        else c_wvalid = 1'b1;
      end else if (m_ph != MWait && $urandom_range(0, 9) == 0) begin
        c_rvalid = 1'b1;
        c_wvalid = $urandom_range(0, 1) == 1;
      end
      #1;
      oh = '0; oh[m_g] = 1'b1;
      e_rd = (m_ph == MIssue) && pend_rd[m_g];
      e_wr = (m_ph == MIssue && !pend_rd[m_g]) ? pend_wr[m_g] : 4'h0;
      total++;
      if ({c_rd, c_wr} !== {e_rd, e_wr}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got=%h want=%h", cyc, {c_rd, c_wr}, {e_rd, e_wr});
      end
      if (m_ph == MIssue) begin
        total++;
        if (c_addr !== pend_addr[m_g]) begin
          bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, c_addr, pend_addr[m_g]);
        end
        if (e_wr != 4'h0) begin
          total++;
          if (c_wdata !== pend_data[m_g]) begin
            bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, c_wdata, pend_data[m_g]);
          end
        end
      end
      e_ack = (m_ph == MIssue && c_rdy) ? oh : '0;
      e_rv  = (m_ph == MWait && c_rvalid) ? oh : '0;
      e_wv  = (m_ph == MWait && c_wvalid) ? oh : '0;
      e_er  = (m_ph == MWait && (c_err || (m_cnt == TO && !c_rvalid && !c_wvalid))) ? oh : '0;
      total++;
      if ({p_ack, p_rvalid, p_wvalid, p_err} !== {e_ack, e_rv, e_wv, e_er}) begin
        bad++; $display("FAIL rnd_pulses cyc=%0d got=%h want=%h", cyc,
                        {p_ack, p_rvalid, p_wvalid, p_err}, {e_ack, e_rv, e_wv, e_er});
      end
      total++;
      if (p_rdata !== ((m_ph == MWait && c_rvalid) ? c_rdata : 32'h0)) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, p_rdata,
                        (m_ph == MWait && c_rvalid) ? c_rdata : 32'h0);
      end
      case (m_ph)
        MFree: begin
          any = 1'b0;
          for (int k = 0; k < N; k++) begin
            w = (m_ptr + k) % N;
            if (!any && pend[w]) begin any = 1'b1; m_g = w; end
          end
          if (any) m_ph = MIssue;
        end
        MIssue: begin
          if (c_rdy) begin
            op_rd = pend_rd[m_g];
            pend[m_g] = 1'b0;
            m_cnt = 0;
            lat = int'($urandom_range(0, 4));
            m_ph = MWait;
          end
        end
        default: begin
          if (c_rvalid || c_wvalid || c_err || m_cnt == TO) begin
            m_ptr = (m_g + 1) % N;
            m_ph = MFree;
            n_done++;
          end else begin
            m_cnt++;
          end
        end
      endcase
      tick();
    end
    total++;
    if (n_done < 50) begin bad++; $display("FAIL rnd_progress got=%0d want>=50", n_done); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
